// File: rtl/r_gpr_bank_if.sv
// Register bank bus: write port, count port, two read ports and the wrap pulse.
// Master drives the selects/data; slave is the register bank.
interface r_gpr_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             reg_load;
    logic [AW-1:0]    load_sel;
    logic [WIDTH-1:0] RegIn;
    logic             cnt_en;
    logic             cnt_dir;
    logic [AW-1:0]    cnt_sel;
    logic [AW-1:0]    rd_a_sel;
    logic [AW-1:0]    rd_b_sel;
    logic [WIDTH-1:0] RegOutA;
    logic [WIDTH-1:0] RegOutB;
    logic             wrap_flag;

    modport master (
        output reg_load, load_sel, RegIn, cnt_en, cnt_dir, cnt_sel, rd_a_sel, rd_b_sel,
        input  RegOutA, RegOutB, wrap_flag
    );

    modport slave (
        input  reg_load, load_sel, RegIn, cnt_en, cnt_dir, cnt_sel, rd_a_sel, rd_b_sel,
        output RegOutA, RegOutB, wrap_flag
    );
endinterface

// File: rtl/r_gpr_bank.sv
// General purpose register bank: one write port, one up/down count port,
// two combinational read ports with optional write forwarding.
module r_gpr_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter int               BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    r_gpr_bank_if.slave   bus
);
    localparam int               AW  = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cnt_cur;
    logic [WIDTH-1:0] cnt_nxt;
    logic             load_act;
    logic             cnt_act;
    logic             wrap_flag_q;
    logic             byp_a;
    logic             byp_b;

    // True when stepping v in the given direction crosses the modulo boundary.
    function automatic logic count_wraps(input logic [WIDTH-1:0] v, input logic dir);
        return dir ? (&v) : (v == '0);
    endfunction

    assign load_act = !bus.reg_load;
    assign cnt_cur  = regs[bus.cnt_sel];
    assign cnt_nxt  = bus.cnt_dir ? (cnt_cur + ONE) : (cnt_cur - ONE);
    // A load to the same register overrides the count entirely, wrap included.
    assign cnt_act  = !bus.cnt_en && !(load_act && (bus.load_sel == bus.cnt_sel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
            wrap_flag_q <= 1'b0;
        end else begin
            wrap_flag_q <= cnt_act && count_wraps(cnt_cur, bus.cnt_dir);
            for (int i = 0; i < DEPTH; i++) begin
                if (load_act && (bus.load_sel == AW'(i))) begin
                    regs[i] <= bus.RegIn;
                end else if (cnt_act && (bus.cnt_sel == AW'(i))) begin
                    regs[i] <= cnt_nxt;
                end
            end
        end
    end

    // Only loads are forwarded; a pending count is visible after the edge.
    assign byp_a = (BYPASS != 0) && load_act && (bus.rd_a_sel == bus.load_sel);
    assign byp_b = (BYPASS != 0) && load_act && (bus.rd_b_sel == bus.load_sel);

    assign bus.RegOutA   = byp_a ? bus.RegIn : regs[bus.rd_a_sel];
    assign bus.RegOutB   = byp_b ? bus.RegIn : regs[bus.rd_b_sel];
    assign bus.wrap_flag = wrap_flag_q;
endmodule

// File: tb/tb_r_gpr_bank.sv
// Directed bench for r_gpr_bank: a forwarding instance and a non-forwarding
// instance share the same stimulus and are checked against a vector table.
module tb_r_gpr_bank;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    r_gpr_bank_if #(.WIDTH(8), .DEPTH(4)) bus_b ();
    r_gpr_bank_if #(.WIDTH(8), .DEPTH(4)) bus_n ();

    assign bus_n.reg_load = bus_b.reg_load;
    assign bus_n.load_sel = bus_b.load_sel;
    assign bus_n.RegIn    = bus_b.RegIn;
    assign bus_n.cnt_en   = bus_b.cnt_en;
    assign bus_n.cnt_dir  = bus_b.cnt_dir;
    assign bus_n.cnt_sel  = bus_b.cnt_sel;
    assign bus_n.rd_a_sel = bus_b.rd_a_sel;
    assign bus_n.rd_b_sel = bus_b.rd_b_sel;

    r_gpr_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .RESET_VAL(8'h5A)) dut_byp (
        .clk(clk), .rst(rst), .bus(bus_b)
    );
    r_gpr_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .RESET_VAL(8'h5A)) dut_nb (
        .clk(clk), .rst(rst), .bus(bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [1:0] lsel;
        logic [7:0] din;
        logic [1:0] cnt;   // 0 none, 1 increment, 2 decrement
        logic [1:0] csel;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] ea_nb;
        logic [7:0] eb;
        logic [7:0] eb_nb;
        logic       ew;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(input logic ld, input logic [1:0] lsel, input logic [7:0] din,
                                input logic [1:0] cnt, input logic [1:0] csel,
                                input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] ea, input logic [7:0] ea_nb,
                                input logic [7:0] eb, input logic [7:0] eb_nb, input logic ew);
        vec_t v;
        v.ld = ld; v.lsel = lsel; v.din = din; v.cnt = cnt; v.csel = csel;
        v.ra = ra; v.rb = rb; v.ea = ea; v.ea_nb = ea_nb; v.eb = eb; v.eb_nb = eb_nb; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus_b.reg_load = ~v.ld;
        bus_b.load_sel = v.lsel;
        bus_b.RegIn    = v.din;
        bus_b.cnt_en   = (v.cnt == 2'd0);
        bus_b.cnt_dir  = (v.cnt == 2'd1);
        bus_b.cnt_sel  = v.csel;
        bus_b.rd_a_sel = v.ra;
        bus_b.rd_b_sel = v.rb;
    endtask

    task automatic sweep_all(input logic [7:0] exp, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus_b.rd_a_sel = 2'(i);
            bus_b.rd_b_sel = 2'(3 - i);
            #1;
            chk({tag, "_a_byp"}, bus_b.RegOutA, exp);
            chk({tag, "_b_byp"}, bus_b.RegOutB, exp);
            chk({tag, "_a_nb"},  bus_n.RegOutA, exp);
            chk({tag, "_b_nb"},  bus_n.RegOutB, exp);
        end
        chk({tag, "_wrap_byp"}, {7'd0, bus_b.wrap_flag}, 8'h00);
        chk({tag, "_wrap_nb"},  {7'd0, bus_n.wrap_flag}, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          ld    lsel   din    cnt   csel   ra     rb     ea     ea_nb  eb     eb_nb  ew
        vt[0]  = mk(1'b1, 2'd0, 8'h11, 2'd0, 2'd0, 2'd0, 2'd1, 8'h11, 8'h5A, 8'h5A, 8'h5A, 1'b0);
        vt[1]  = mk(1'b1, 2'd1, 8'h22, 2'd0, 2'd0, 2'd0, 2'd1, 8'h11, 8'h11, 8'h22, 8'h5A, 1'b0);
        vt[2]  = mk(1'b1, 2'd2, 8'h33, 2'd0, 2'd0, 2'd2, 2'd0, 8'h33, 8'h5A, 8'h11, 8'h11, 1'b0);
        vt[3]  = mk(1'b1, 2'd3, 8'h44, 2'd0, 2'd0, 2'd1, 2'd3, 8'h22, 8'h22, 8'h44, 8'h5A, 1'b0);
        vt[4]  = mk(1'b0, 2'd0, 8'hFF, 2'd0, 2'd0, 2'd3, 2'd2, 8'h44, 8'h44, 8'h33, 8'h33, 1'b0);
        vt[5]  = mk(1'b0, 2'd1, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 8'h11, 8'h11, 1'b0);
        vt[6]  = mk(1'b0, 2'd3, 8'hA5, 2'd0, 2'd0, 2'd1, 2'd3, 8'h22, 8'h22, 8'h44, 8'h44, 1'b0);
        vt[7]  = mk(1'b1, 2'd2, 8'hC3, 2'd0, 2'd0, 2'd2, 2'd2, 8'hC3, 8'h33, 8'hC3, 8'h33, 1'b0);
        vt[8]  = mk(1'b0, 2'd2, 8'h00, 2'd0, 2'd0, 2'd2, 2'd1, 8'hC3, 8'hC3, 8'h22, 8'h22, 1'b0);
        vt[9]  = mk(1'b1, 2'd1, 8'hFE, 2'd0, 2'd0, 2'd1, 2'd0, 8'hFE, 8'h22, 8'h11, 8'h11, 1'b0);
        vt[10] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 1'b0);
        vt[11] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        vt[12] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        vt[13] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 2'd1, 2'd1, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0);
        vt[14] = mk(1'b1, 2'd1, 8'h00, 2'd0, 2'd0, 2'd1, 2'd0, 8'h00, 8'h01, 8'h11, 8'h11, 1'b0);
        vt[15] = mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vt[16] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd1, 2'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        vt[17] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd1, 2'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        vt[18] = mk(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 2'd0, 2'd1, 8'hFF, 8'h11, 8'hFF, 8'hFF, 1'b0);
        vt[19] = mk(1'b1, 2'd0, 8'h7F, 2'd1, 2'd0, 2'd0, 2'd3, 8'h7F, 8'hFF, 8'h44, 8'h44, 1'b0);
        vt[20] = mk(1'b1, 2'd2, 8'h05, 2'd0, 2'd0, 2'd0, 2'd2, 8'h7F, 8'h7F, 8'h05, 8'hC3, 1'b0);
        vt[21] = mk(1'b1, 2'd3, 8'h10, 2'd1, 2'd2, 2'd2, 2'd3, 8'h05, 8'h05, 8'h10, 8'h44, 1'b0);
        vt[22] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd2, 2'd3, 8'h06, 8'h06, 8'h10, 8'h10, 1'b0);
        vt[23] = mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 2'd3, 2'd3, 8'h10, 8'h10, 8'h10, 8'h10, 1'b0);
        vt[24] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd3, 2'd0, 8'h0F, 8'h0F, 8'h7F, 8'h7F, 1'b0);

        // Reset visible before any clock edge, then held through idle cycles.
        rst = 1'b1;
        drive(mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        sweep_all(8'h5A, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sweep_all(8'h5A, "rst_hold");

        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            drive(vt[k]);
            #2;
            chk($sformatf("v%0d_a_byp", k), bus_b.RegOutA, vt[k].ea);
            chk($sformatf("v%0d_a_nb", k),  bus_n.RegOutA, vt[k].ea_nb);
            chk($sformatf("v%0d_b_byp", k), bus_b.RegOutB, vt[k].eb);
            chk($sformatf("v%0d_b_nb", k),  bus_n.RegOutB, vt[k].eb_nb);
            chk($sformatf("v%0d_wrap_byp", k), {7'd0, bus_b.wrap_flag}, {7'd0, vt[k].ew});
            chk($sformatf("v%0d_wrap_nb", k),  {7'd0, bus_n.wrap_flag}, {7'd0, vt[k].ew});
        end

        // Reset mid-count: r1=FF wraps, then rst lands between edges.
        @(negedge clk);
        drive(mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        @(posedge clk);
        #2;
        chk("mid_pre_val",  bus_n.RegOutA, 8'h00);
        chk("mid_pre_wrap", {7'd0, bus_n.wrap_flag}, 8'h01);
        rst = 1'b1;
        #1;
        chk("mid_rst_a_byp", bus_b.RegOutA, 8'h5A);
        chk("mid_rst_a_nb",  bus_n.RegOutA, 8'h5A);
        chk("mid_rst_wrap_byp", {7'd0, bus_b.wrap_flag}, 8'h00);
        chk("mid_rst_wrap_nb",  {7'd0, bus_n.wrap_flag}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("resume_1", bus_n.RegOutA, 8'h5B);
        chk("resume_1_wrap", {7'd0, bus_n.wrap_flag}, 8'h00);
        @(posedge clk);
        #2;
        chk("resume_2", bus_b.RegOutB, 8'h5C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
